uart_tx_frame: RTL



---
 rtl/uart_tx_frame.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   Parametrised UART transmitter. Sends one frame per accepted word:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   then STOP_BITS stop bits (1). Every bit lasts CYCLE clocks, where
//   CYCLE = CLK_FRE*1e6/BAUD_RATE (integer truncation).
//
// Parameters
//   CLK_FRE    clock frequency in MHz
//   BAUD_RATE  serial baud rate in bit/s
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   tx_data        word to send, LSB transmitted first
//   tx_data_valid  tx_data valid
//   tx_data_ready  block can accept a word this cycle (registered)
//   tx_busy        a frame is in progress (registered)
//   tx_pin         serial output, idles high (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_data_valid,
    output logic                 tx_data_ready,
    output logic                 tx_busy,
    output logic                 tx_pin
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    // Guarded so an illegal CYCLE reports the error below instead of a
    // zero-width vector.
    localparam int CNT_W = (CYCLE < 2) ? 1 : $clog2(CYCLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    // -------------------------------------------------------------------------
    // Compile-time parameter legality
    // -------------------------------------------------------------------------
    generate
        if (CYCLE < 2) begin : g_bad_cycle
            $error("uart_tx_frame: CLK_FRE*1e6/BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   latch;

    logic                   bit_done;
    logic                   parity_bit;

    always_comb begin
        bit_done   = (baud_cnt == CNT_LAST);
        // Even parity makes the total count of ones even; odd inverts it.
        parity_bit = (PARITY == 1) ? ~(^latch) : (^latch);
    end

    // -------------------------------------------------------------------------
    // Frame sequencer. tx_pin is loaded with the value of the next bit on the
    // same edge that the state / bit index moves, so the line and the state
    // are always aligned and every bit lasts exactly CYCLE clocks.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            stop_cnt      <= 1'b0;
            latch         <= '0;
            tx_pin        <= 1'b1;
            tx_data_ready <= 1'b0;
            tx_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= 1'b0;
                    if (!tx_data_ready) begin
                        // First edge after reset release, no word can be
                        // accepted on this edge.
                        tx_data_ready <= 1'b1;
                    end else if (tx_data_valid) begin
                        latch         <= tx_data;
                        tx_data_ready <= 1'b0;
                        tx_busy       <= 1'b1;
                        tx_pin        <= 1'b0;
                        state         <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_pin   <= latch[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                tx_pin <= parity_bit;
                                state  <= PARITY_BIT;
                            end else begin
                                tx_pin   <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_pin  <= latch[bit_idx + 1'b1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY_BIT: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        tx_pin   <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            tx_pin        <= 1'b1;
                            tx_data_ready <= 1'b1;
                            tx_busy       <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    baud_cnt      <= '0;
                    tx_pin        <= 1'b1;
                    tx_data_ready <= 1'b0;
                    tx_busy       <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
